// File: rtl/conv_kxk_stream.sv
// rtl/conv_kxk_stream.sv - streaming 3x3 valid convolution, OUT_CH parallel channels
//
// Purpose: consumes a raster-order unsigned pixel stream for one IMG_W x IMG_H
// frame and produces, for every complete 3x3 window, OUT_CH signed results
// (kernel dot product plus bias, saturated, optional ReLU). Stride 1 or 2.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   sta, mode_i       frame start; mode bit0 = ReLU, bit1 = stride 2 (sampled on start)
//   pix_i/pix_valid_i/pix_ready_o   pixel stream handshake
//   w_we_i, w_ch_i, weight_i, bias_i  per-channel kernel/bias write (IDLE only)
//   conv_o, valid_o   per-channel results, channel 0 in the LSBs
//   busy_o, done_o    frame in progress; one-cycle end-of-frame pulse
module conv_kxk_stream #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int OUT_CH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sta,
    input  logic [1:0]               mode_i,
    input  logic [DATA_W-1:0]        pix_i,
    input  logic                     pix_valid_i,
    output logic                     pix_ready_o,
    input  logic                     w_we_i,
    input  logic [4:0]               w_ch_i,
    input  logic [9*DATA_W-1:0]      weight_i,
    input  logic [ACC_W-1:0]         bias_i,
    output logic [OUT_CH*ACC_W-1:0]  conv_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H + 1);
    localparam int PROD_W = 2 * DATA_W + 1;
    // Nine products need 4 growth bits; one more bit covers the bias addition.
    localparam int SUM_W  = ((PROD_W + 4 > ACC_W) ? PROD_W + 4 : ACC_W) + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   drain_cnt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          relu_en;
    logic          stride2;

    logic [DATA_W-1:0] lb0 [IMG_W];   // previous row
    logic [DATA_W-1:0] lb1 [IMG_W];   // row before previous
    logic [DATA_W-1:0] win     [3][3];
    logic [DATA_W-1:0] win_nxt [3][3];

    logic [9*DATA_W-1:0]      kern   [OUT_CH];
    logic signed [ACC_W-1:0]  bias_r [OUT_CH];

    logic signed [PROD_W-1:0] prod_nxt [OUT_CH][9];
    logic signed [PROD_W-1:0] prod_q   [OUT_CH][9];
    logic                     v1;

    logic signed [SUM_W-1:0]  sum_c [OUT_CH];
    logic [ACC_W-1:0]         res_c [OUT_CH];

    logic accept;
    logic sta_acc;
    logic last_pix;
    logic fire;

    assign accept   = pix_valid_i && (state == S_RUN);
    assign sta_acc  = sta && (state == S_IDLE);
    assign last_pix = accept && (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
    // Window is complete once two full rows and two columns precede the pixel;
    // stride 2 keeps only even offsets from that origin.
    assign fire     = accept && (row >= RW'(2)) && (col >= CW'(2)) &&
                      (!stride2 || (!row[0] && !col[0]));

    function automatic logic signed [PROD_W-1:0] mul(input logic [DATA_W-1:0] p,
                                                     input logic [DATA_W-1:0] w);
        logic signed [PROD_W-1:0] pe;
        logic signed [PROD_W-1:0] we;
        pe = $signed({{(PROD_W-DATA_W){1'b0}}, p});
        we = $signed({{(PROD_W-DATA_W){w[DATA_W-1]}}, w});
        return pe * we;
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == S_DRAIN);
        end
    end

    always_comb begin
        state_nxt   = state;
        pix_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (sta) state_nxt = S_RUN;
            end
            S_RUN: begin
                pix_ready_o = 1'b1;
                if (last_pix) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- position counters and mode ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            relu_en <= 1'b0;
            stride2 <= 1'b0;
        end else if (sta_acc) begin
            col     <= '0;
            row     <= '0;
            relu_en <= mode_i[0];
            stride2 <= mode_i[1];
        end else if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // ---------------- line buffers and window ----------------
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = lb1[col];
        win_nxt[1][2] = lb0[col];
        win_nxt[2][2] = pix_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_i;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= win_nxt[r][c];
        end
    end

    // ---------------- kernel / bias storage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < OUT_CH; c++) begin
                kern[c]   <= '0;
                bias_r[c] <= '0;
            end
        end else if (w_we_i && (state == S_IDLE)) begin
            // Channels at or above OUT_CH never match and are dropped.
            for (int c = 0; c < OUT_CH; c++) begin
                if (w_ch_i == 5'(c)) begin
                    kern[c]   <= weight_i;
                    bias_r[c] <= $signed(bias_i);
                end
            end
        end
    end

    // ---------------- stage 1: products ----------------
    // Products use the window including the incoming pixel so the result
    // lands two cycles after the completing pixel.
    always_comb begin
        for (int ch = 0; ch < OUT_CH; ch++)
            for (int k = 0; k < 9; k++)
                prod_nxt[ch][k] = mul(win_nxt[k/3][k%3], kern[ch][k*DATA_W +: DATA_W]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            for (int ch = 0; ch < OUT_CH; ch++)
                for (int k = 0; k < 9; k++)
                    prod_q[ch][k] <= '0;
        end else begin
            v1 <= fire;
            if (fire) begin
                for (int ch = 0; ch < OUT_CH; ch++)
                    for (int k = 0; k < 9; k++)
                        prod_q[ch][k] <= prod_nxt[ch][k];
            end
        end
    end

    // ---------------- stage 2: sum, bias, saturate, ReLU ----------------
    always_comb begin
        for (int ch = 0; ch < OUT_CH; ch++) begin
            sum_c[ch] = SUM_W'(bias_r[ch]);
            for (int k = 0; k < 9; k++)
                sum_c[ch] = sum_c[ch] + SUM_W'(prod_q[ch][k]);
            if (sum_c[ch] > SAT_MAX)
                res_c[ch] = SAT_MAX[ACC_W-1:0];
            else if (sum_c[ch] < SAT_MIN)
                res_c[ch] = SAT_MIN[ACC_W-1:0];
            else
                res_c[ch] = sum_c[ch][ACC_W-1:0];
            if (relu_en && res_c[ch][ACC_W-1])
                res_c[ch] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= v1;
            if (v1) begin
                for (int ch = 0; ch < OUT_CH; ch++)
                    conv_o[ch*ACC_W +: ACC_W] <= res_c[ch];
            end
        end
    end

endmodule

// File: doc/conv_kxk_stream.md
CONV_KXK_STREAM -- requirements
Module: conv_kxk_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel and weight width.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator, bias and output width per channel.
REQ-003 SHALL have parameter IMG_W, default 28: frame width in pixels, 3..1023.
REQ-004 SHALL have parameter IMG_H, default 28: frame height in rows, 3..1023.
REQ-005 SHALL have parameter OUT_CH, default 4: parallel output channels, 1..32.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have clk, input, 1: clock, rising edge.
REQ-008 SHALL have rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have sta, input, 1: frame start pulse.
REQ-010 SHALL have mode_i, input, 2: bit0 = ReLU enable, bit1 = stride 2. Both are sampled on an accepted sta.
REQ-011 SHALL have pix_i, input, DATA_W: unsigned pixel, raster order.
REQ-012 SHALL have pix_valid_i, input, 1: pix_i qualifier.
REQ-013 SHALL have pix_ready_o, output, 1: the pixel is accepted when valid and ready are both high.
REQ-014 SHALL have w_we_i, input, 1: weight/bias write strobe.
REQ-015 SHALL have w_ch_i, input, 5: target channel.
REQ-016 SHALL have weight_i, input, 9*DATA_W: signed 3x3 kernel, tap 0 in the LSBs, row-major.
REQ-017 SHALL have bias_i, input, ACC_W: signed bias.
REQ-018 SHALL have conv_o, output, OUT_CH*ACC_W: signed results, channel 0 in the LSBs.
REQ-019 SHALL have valid_o, output, 1: conv_o qualifier, one cycle per output pixel.
REQ-020 SHALL have busy_o, output, 1: high outside IDLE.
REQ-021 SHALL have done_o, output, 1: one-cycle pulse at end of frame.

Function
REQ-022 SHALL implement the states IDLE, RUN, DRAIN and DONE:
- IDLE to RUN on sta.
- RUN to DRAIN when pixel IMG_W*IMG_H-1 is accepted.
- DRAIN to DONE after 2 cycles.
- DONE to IDLE after 1 cycle.
REQ-023 SHALL ignore sta outside IDLE.
REQ-024 SHALL drive pix_ready_o high only in RUN; pixels presented in any other state are not consumed.
REQ-025 SHALL write the kernel and bias of channel w_ch_i on w_we_i in IDLE only:
- writes in other states are dropped;
- writes with w_ch_i >= OUT_CH are dropped.
REQ-026 SHALL hold two IMG_W-deep line buffers plus a 3x3 window register, advanced only on accepted pixels; pix_valid_i gaps freeze all state.
REQ-027 SHALL track column 0..IMG_W-1 and row 0..IMG_H-1, both cleared on accepted sta; the column wraps to 0 and the row increments after column IMG_W-1.
REQ-028 SHALL form an output only when the accepted pixel has row>=2 and col>=2 (valid convolution, no padding).
REQ-029 SHALL, in stride-2 mode, additionally require (row-2) and (col-2) both even.
REQ-030 SHALL compute per channel: sum of 9 (unsigned pixel x signed weight) products plus bias, in full precision.
REQ-031 SHALL saturate each channel result to the signed ACC_W range.
REQ-032 SHALL, when ReLU is enabled, replace negative results with 0 after saturation.
REQ-033 SHALL assert valid_o exactly 2 cycles after the accepted pixel that completes the window:
- stage 1 registers the products;
- stage 2 registers the sum, bias, saturation and ReLU.
REQ-034 SHALL hold conv_o at its last value while valid_o is low; there is no output backpressure.
REQ-035 SHALL let the last window's valid_o fall within DRAIN, with done_o asserted in DONE after it.
REQ-036 SHALL assert busy_o in RUN, DRAIN and DONE.

Reset
REQ-037 SHALL clear the following asynchronously while rst_n is low:
- state to IDLE;
- counters, line buffers, window and pipeline to 0;
- all kernels and biases to 0;
- conv_o to 0;
- valid_o, busy_o, done_o and pix_ready_o to 0.
REQ-038 SHALL make reset mid-frame abort the frame with no further valid_o or done_o; a new frame requires weight reload and sta.

Verification (IMG_W=IMG_H=5, OUT_CH=2, ACC_W=16)
REQ-039 SHALL cover this scenario: all weights 1, bias 0, pixels all 1, mode 00 -> 9 valid_o pulses, each channel =9, done_o one cycle after the last pulse.
REQ-040 SHALL cover this scenario: channel1 bias -20, other inputs as REQ-039 -> ch1 = -11 with mode 00, and ch1 = 0 with mode 01.
REQ-041 SHALL cover this scenario: mode 10, pixel value = row*5+col, ch0 center weight 1, others 0 -> 4 outputs: 6, 8, 16, 18.
REQ-042 SHALL cover this scenario: pixels 255, weights 127, bias 0 -> every output saturates to 32767; weights -128 -> -32768.
REQ-043 SHALL cover this scenario: REQ-039 stimulus with pix_valid_i randomly low 50% of cycles -> identical output sequence, and no valid_o without a preceding accepted pixel.
REQ-044 SHALL cover this scenario: rst_n low after 12 accepted pixels -> all outputs 0, no done_o; a subsequent reload and frame reproduces REQ-039.
